spi_slave_rx: RTL
=================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, flip-flop depth of the input synchronizers on sclk, cs and mosi.
REQ-002 SHALL have parameter DATA_W, default 8, bits per SPI word.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  system clock; rst  input  1  synchronous active-high reset.
REQ-004 cpol  input  1  SPI clock idle level, static during a frame.
REQ-005 cpha  input  1  SPI clock phase: 0 = sample on leading edge, 1 = sample on trailing edge; static during a frame.
REQ-006 sclk  input  1  SPI clock from the master, asynchronous.
REQ-007 cs  input  1  chip select, active-low, asynchronous.
REQ-008 mosi  input  1  serial data from the master, MSB first.
REQ-009 tx_dat  input  DATA_W  word returned on miso, captured at frame start and at each word boundary.
REQ-010 miso  output  1  serial data to the master, MSB first.
REQ-011 rx_dat  output  DATA_W  last complete received word, held until the next word completes.
REQ-012 rx_valid  output  1  one-clk pulse when rx_dat is updated.
REQ-013 busy  output  1  high while the synchronized cs is low.
REQ-014 frame_err  output  1  one-clk pulse when cs rises with a partial word.
REQ-015 mode  output  2  {cpol,cpha}, combinational.

Function
REQ-016 sclk, cs and mosi SHALL each pass through SYNC_STAGES flops; all logic SHALL use only the synchronized copies.
REQ-017 The sample edge SHALL be rising when cpol^cpha=0 and falling otherwise; the shift edge is the opposite edge.
REQ-018 Edges SHALL be detected by comparing the synchronized sclk with its value one clk earlier. Supported sclk is at most clk/4, with each sclk level held for at least 2 clk.
REQ-019 The FSM SHALL use states IDLE, ACTIVE and ABORT.
  - IDLE->ACTIVE: on a synchronized cs falling edge.
  - ACTIVE->IDLE: cs rises with bit_cnt=0.
  - ACTIVE->ABORT: cs rises with bit_cnt!=0.
  - ABORT->IDLE: unconditionally, after one clk.
REQ-020 In ACTIVE, on each sample edge, the shift register SHALL shift left with the synchronized mosi entering bit 0, and bit_cnt SHALL increment modulo DATA_W.
REQ-021 On the sample edge that completes a word (bit_cnt = DATA_W-1), rx_dat SHALL load the full word in the next clk and rx_valid SHALL pulse in that same clk. Latency is SYNC_STAGES+2 clk from the raw sclk edge.
REQ-022 Within one cs-low frame, words SHALL be received back-to-back with no gap; bit_cnt wraps to 0 and each word produces its own rx_valid.
REQ-023 ABORT SHALL pulse frame_err for one clk, discard the partial word, leave rx_dat unchanged and assert no rx_valid.
REQ-024 On entry to ACTIVE, the tx shift register SHALL load tx_dat.
  - cpha=0: miso = tx_dat[DATA_W-1] immediately.
  - cpha=1: miso holds the MSB and shifts first on the first leading edge, which counts as the shift edge.
REQ-025 On each shift edge, the tx shift register SHALL shift left and miso SHALL present the new MSB. At a word boundary the register SHALL reload from tx_dat.
REQ-026 miso SHALL be 0 whenever the FSM is in IDLE or ABORT.
REQ-027 sclk edges while cs is high SHALL be ignored.
REQ-028 A cs falling edge and a sclk edge detected in the same clk: the FSM SHALL enter ACTIVE and the sclk edge SHALL be ignored.

Reset
REQ-029 While rst=1 on a clk edge, the block SHALL set: FSM=IDLE, bit_cnt=0, both shift registers=0, rx_dat=0, rx_valid=0, frame_err=0, miso=0, busy=0, and all synchronizer flops to idle levels (cs=1, sclk=cpol, mosi=0).
REQ-030 Reset mid-frame SHALL abort without a frame_err pulse. After reset release with cs still low, the block SHALL wait for the next cs falling edge.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, default DATA_W and SYNC_STAGES, and the mode encoding (MODE0..MODE3 = 2'b00..2'b11).
REQ-032 One sub-module, spi_sync (a parameterized N-flop synchronizer with reset value), SHALL be instantiated three times.

Verification
REQ-033 Mode 0, clk/4 sclk, master sends 0xA5 -> exactly one rx_valid pulse with rx_dat=0xA5, frame_err=0.
REQ-034 Mode 3, tx_dat=0xC3, master sends 0x3C -> rx_dat=0x3C, and the master captures 0xC3 on miso.
REQ-035 Modes 1 and 2, one cs frame carrying 0x12 then 0x34 -> two rx_valid pulses, rx_dat=0x12 then 0x34.
REQ-036 Mode 0, cs raised after 5 bits of 0xFF following a prior 0x5A -> frame_err pulse, no rx_valid, rx_dat stays 0x5A.
REQ-037 rst pulsed after bit 3 of a frame, then a new cs frame sending 0x81 -> outputs return to reset values, frame_err=0, then rx_dat=0x81.

Source files
------------

// File: rtl/spi_slave_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave_rx_pkg
//  Description : Shared definitions for the SPI slave receiver. Holds the
//                control FSM state encoding, the default word width and
//                synchronizer depth, the SPI mode encoding and a helper that
//                selects the sample edge for a mode.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_rx_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // SPI mode encoding, {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_ABORT  = 2'b10
    } state_e;

    // Data is sampled on the rising sclk edge when cpol and cpha agree,
    // otherwise on the falling edge.
    function automatic logic sample_on_rise(input logic [1:0] m);
        return ~(m[1] ^ m[0]);
    endfunction

endpackage : spi_slave_rx_pkg
`default_nettype wire

// File: rtl/spi_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_sync
//  Description : N-flop synchronizer for one asynchronous input bit. The
//                reset value is a port so it can follow a run-time level
//                (for example the sclk idle level).
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset
//                rst_val - value loaded into every stage during reset
//                d       - asynchronous input
//                q       - synchronized output
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    generate
        if (STAGES == 1) begin : g_single
            always_comb sync_d = d;
        end else begin : g_chain
            always_comb sync_d = {sync_q[STAGES-2:0], d};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{rst_val}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : spi_sync
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave_rx
//  Description : SPI slave receiver/transmitter for all four SPI modes.
//                sclk, cs and mosi are oversampled by clk through
//                synchronizers; edges are found by comparing the synchronized
//                sclk with its previous value. Words are received MSB first,
//                back to back within one cs-low frame, while tx_dat is
//                returned on miso.
//  Ports       : clk, rst   - system clock, synchronous active-high reset
//                cpol, cpha - SPI mode, static during a frame
//                sclk, cs, mosi - asynchronous SPI inputs (cs active low)
//                tx_dat     - word returned on miso
//                miso       - serial data to the master
//                rx_dat     - last complete received word
//                rx_valid   - one-clk pulse when rx_dat updates
//                busy       - synchronized cs is low
//                frame_err  - one-clk pulse when cs rises mid-word
//                mode       - {cpol, cpha}
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    input  logic [DATA_W-1:0] tx_dat,
    output logic              miso,
    output logic [DATA_W-1:0] rx_dat,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err,
    output logic [1:0]        mode
);

    localparam int               CNT_W      = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DATA_W - 1);
    localparam int               FLUSH_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Input synchronizers, reset to the bus idle levels
    // ------------------------------------------------------------------
    logic sclk_s;
    logic cs_s;
    logic mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .rst_val (cpol),
        .d       (sclk),
        .q       (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b1),
        .d       (cs),
        .q       (cs_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b0),
        .d       (mosi),
        .q       (mosi_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0] rx_sr_q,     rx_sr_d;
    logic [DATA_W-1:0] tx_sr_q,     tx_sr_d;
    logic [DATA_W-1:0] rx_dat_q,    rx_dat_d;
    logic              rx_valid_q,  rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              miso_q,      miso_d;
    logic              word_done_q, word_done_d;
    logic              first_q,     first_d;
    logic              sclk_prev_q, sclk_prev_d;
    logic              cs_prev_q,   cs_prev_d;
    logic [FLUSH_W-1:0] flush_q,    flush_d;

    logic sclk_rise;
    logic sclk_fall;
    logic sample_edge;
    logic shift_edge;
    logic cs_fall;
    logic cs_rise;

    assign mode        = {cpol, cpha};
    assign sclk_rise   =  sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s &  sclk_prev_q;
    assign sample_edge = sample_on_rise(mode) ? sclk_rise : sclk_fall;
    assign shift_edge  = sample_on_rise(mode) ? sclk_fall : sclk_rise;
    assign cs_fall     =  cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q &  cs_s;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_dat_d    = rx_dat_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;
        word_done_d = 1'b0;
        first_d     = first_q;
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        flush_d     = flush_q;

        // The synchronizers come out of reset at idle levels. Until their
        // contents have been replaced by real input samples, a cs falling
        // edge is an artefact of reset and must not start a frame.
        if (flush_q != '0) begin
            flush_d = flush_q - FLUSH_W'(1);
        end

        // The word was shifted in on the previous clk; publish it now.
        if (word_done_q) begin
            rx_dat_d   = rx_sr_q;
            rx_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                // Any sclk edge in this same clk is ignored.
                if (cs_fall && (flush_q == '0)) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    tx_sr_d   = tx_dat;
                    miso_d    = tx_dat[DATA_W-1];
                    // In cpha=1 the first leading edge is a shift edge that
                    // must present the already-loaded MSB, not shift past it.
                    first_d   = cpha;
                end
            end

            ST_ACTIVE: begin
                if (cs_rise) begin
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    first_d   = 1'b0;
                    if (bit_cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_ABORT;
                        frame_err_d = 1'b1;
                    end
                end else if (sample_edge) begin
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d   = '0;
                        word_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    if (first_q) begin
                        first_d = 1'b0;
                        miso_d  = tx_sr_q[DATA_W-1];
                    end else if (bit_cnt_q == '0) begin
                        // Word boundary: fetch the next word to return.
                        tx_sr_d = tx_dat;
                        miso_d  = tx_dat[DATA_W-1];
                    end else begin
                        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        miso_d  = tx_sr_q[DATA_W-2];
                    end
                end
            end

            ST_ABORT: begin
                state_d   = ST_IDLE;
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                rx_sr_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rx_dat_q    <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            word_done_q <= 1'b0;
            first_q     <= 1'b0;
            sclk_prev_q <= cpol;
            cs_prev_q   <= 1'b1;
            flush_q     <= FLUSH_INIT;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_dat_q    <= rx_dat_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            word_done_q <= word_done_d;
            first_q     <= first_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            flush_q     <= flush_d;
        end
    end

    assign miso      = miso_q;
    assign rx_dat    = rx_dat_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = ~cs_s;

endmodule : spi_slave_rx
`default_nettype wire
